// File: rtl/cop1_pkg.sv
// Shared Cop1 definitions: producer indices, register index width and the write-request record.
package cop1_pkg;

    localparam int unsigned NUM_PROD  = 3;
    localparam int unsigned PROD_FPU  = 0;
    localparam int unsigned PROD_LD   = 1;
    localparam int unsigned PROD_MT   = 2;
    localparam int unsigned FPU_REG_W = 5;

    typedef struct packed {
        logic                 valid;
        logic [FPU_REG_W-1:0] wreg;
        logic [31:0]          data;
    } wr_req_t;

endpackage

// File: rtl/fpu_wb_arbiter.sv
// Three-way fixed-priority arbiter with per-requester aging counters; a requester that has
// lost MAX_WAIT times in a row is promoted above the fixed order.
module fpu_wb_arbiter
    import cop1_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NUM_PROD-1:0] req_i,
    output logic [NUM_PROD-1:0] gnt_o
);

    localparam int unsigned      CntW     = 4;
    localparam logic [CntW-1:0]  MaxWaitC = CntW'(MAX_WAIT);

    logic [CntW-1:0]     cnt_q [NUM_PROD];
    logic [CntW-1:0]     cnt_d [NUM_PROD];
    logic [NUM_PROD-1:0] urgent;
    logic                found;

    always_comb begin
        urgent = '0;
        gnt_o  = '0;
        found  = 1'b0;
        for (int i = 0; i < NUM_PROD; i++) begin
            urgent[i] = req_i[i] && (cnt_q[i] == MaxWaitC);
        end
        // Aged requesters first, lowest index wins ties; then plain fixed order.
        for (int i = 0; i < NUM_PROD; i++) begin
            if (urgent[i] && !found) begin
                gnt_o[i] = 1'b1;
                found    = 1'b1;
            end
        end
        for (int i = 0; i < NUM_PROD; i++) begin
            if (req_i[i] && !found) begin
                gnt_o[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_PROD; i++) begin
            cnt_d[i] = cnt_q[i];
            if (!req_i[i] || gnt_o[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] != MaxWaitC) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_PROD; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_PROD; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

endmodule

// File: rtl/fpu_writeback_scheduler.sv
// Cop1 register-bank write sequencer: one-entry buffer per producer, aged arbitration onto a
// single registered write port, and a busy scoreboard that drives the issue stall.
module fpu_writeback_scheduler
    import cop1_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 4,
    parameter int unsigned NREGS    = 32
) (
    input  logic                 iCLK,
    input  logic                 iCLR,
    input  logic                 iFpuValid,
    input  logic [FPU_REG_W-1:0] iFpuReg,
    input  logic [31:0]          iFpuData,
    output logic                 oFpuReady,
    input  logic                 iLdValid,
    input  logic [FPU_REG_W-1:0] iLdReg,
    input  logic [31:0]          iLdData,
    output logic                 oLdReady,
    input  logic                 iMtValid,
    input  logic [FPU_REG_W-1:0] iMtReg,
    input  logic [31:0]          iMtData,
    output logic                 oMtReady,
    input  logic                 iIssueValid,
    input  logic [FPU_REG_W-1:0] iIssueSrc1,
    input  logic [FPU_REG_W-1:0] iIssueSrc2,
    input  logic [FPU_REG_W-1:0] iIssueDest,
    input  logic                 iIssueUsesSrc2,
    input  logic                 iIssueWrites,
    output logic                 oStall,
    output logic                 oRegWrite,
    output logic [FPU_REG_W-1:0] oWriteRegister,
    output logic [31:0]          oWriteData,
    output logic [NREGS-1:0]     oBusy
);

    wr_req_t              in_req [NUM_PROD];
    wr_req_t              buf_q  [NUM_PROD];
    wr_req_t              buf_d  [NUM_PROD];
    logic [NUM_PROD-1:0]  buf_valid;
    logic [NUM_PROD-1:0]  gnt;
    logic [NUM_PROD-1:0]  ready;

    logic                 reg_write_q, reg_write_d;
    logic [FPU_REG_W-1:0] write_reg_q, write_reg_d;
    logic [31:0]          write_data_q, write_data_d;
    logic [NREGS-1:0]     busy_q, busy_d;
    logic                 issue_fire;

    function automatic logic busy_at(input logic [NREGS-1:0] b, input logic [FPU_REG_W-1:0] idx);
        logic bit_v;
        bit_v = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            if (FPU_REG_W'(i) == idx) bit_v = b[i];
        end
        return bit_v;
    endfunction

    always_comb begin
        in_req[PROD_FPU] = '{valid: iFpuValid, wreg: iFpuReg, data: iFpuData};
        in_req[PROD_LD]  = '{valid: iLdValid,  wreg: iLdReg,  data: iLdData};
        in_req[PROD_MT]  = '{valid: iMtValid,  wreg: iMtReg,  data: iMtData};
    end

    // Ready depends only on buffer state and the grant, never on the incoming valid.
    always_comb begin
        for (int i = 0; i < NUM_PROD; i++) begin
            buf_valid[i] = buf_q[i].valid;
            ready[i]     = !buf_q[i].valid || gnt[i];
        end
    end

    assign oFpuReady = ready[PROD_FPU];
    assign oLdReady  = ready[PROD_LD];
    assign oMtReady  = ready[PROD_MT];

    fpu_wb_arbiter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_arbiter (
        .clk_i (iCLK),
        .rst_i (iCLR),
        .req_i (buf_valid),
        .gnt_o (gnt)
    );

    always_comb begin
        for (int i = 0; i < NUM_PROD; i++) begin
            buf_d[i] = buf_q[i];
            if (gnt[i]) buf_d[i].valid = 1'b0;
            if (in_req[i].valid && ready[i]) buf_d[i] = in_req[i];
        end
    end

    always_comb begin
        reg_write_d  = 1'b0;
        write_reg_d  = write_reg_q;
        write_data_d = write_data_q;
        for (int i = 0; i < NUM_PROD; i++) begin
            if (gnt[i]) begin
                reg_write_d  = 1'b1;
                write_reg_d  = buf_q[i].wreg;
                write_data_d = buf_q[i].data;
            end
        end
    end

    assign oStall = iIssueValid &&
                    (busy_at(busy_q, iIssueSrc1) ||
                     (iIssueUsesSrc2 && busy_at(busy_q, iIssueSrc2)) ||
                     (iIssueWrites && busy_at(busy_q, iIssueDest)));

    assign issue_fire = iIssueValid && !oStall && iIssueWrites;

    // Set is applied after clear so a freshly issued write keeps the bit pending.
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < NREGS; i++) begin
            if (reg_write_q && (FPU_REG_W'(i) == write_reg_q)) busy_d[i] = 1'b0;
            if (issue_fire && (FPU_REG_W'(i) == iIssueDest)) busy_d[i] = 1'b1;
        end
    end

    always_ff @(posedge iCLK or posedge iCLR) begin
        if (iCLR) begin
            for (int i = 0; i < NUM_PROD; i++) begin
                buf_q[i] <= '0;
            end
            reg_write_q  <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
            busy_q       <= '0;
        end else begin
            for (int i = 0; i < NUM_PROD; i++) begin
                buf_q[i] <= buf_d[i];
            end
            reg_write_q  <= reg_write_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
            busy_q       <= busy_d;
        end
    end

    assign oRegWrite      = reg_write_q;
    assign oWriteRegister = write_reg_q;
    assign oWriteData     = write_data_q;
    assign oBusy          = busy_q;

endmodule

// File: doc/fpu_writeback_scheduler.md
Name: fpu_writeback_scheduler

Overview:
- Sequences all writes into the Cop1 FPU register bank.
- Three producers share the bank's single write port: the multicycle FPU datapath result, LWC1 load data and MTC1 move data. The block arbitrates them with one-entry buffers.
- Holds a 32-entry busy scoreboard, so issue logic stalls on RAW/WAW hazards against writes still in flight.
- Sits between the Cop1 control/datapath and the register bank write inputs (RegWrite, WriteRegister, WriteData).

Parameters:
- MAX_WAIT, 4, cycles a buffered request may lose arbitration before it is forced to top priority (anti-starvation); legal range 1..15.
- NREGS, 32, FPU register count; sets the scoreboard width; index width is fixed at 5.

Ports:
- iCLK  in  1  clock; all state updates on posedge.
- iCLR  in  1  reset, asynchronous, active-high.
- iFpuValid/iLdValid/iMtValid  in  1 each  producer request valid (0=FPU, 1=LWC1, 2=MTC1).
- iFpuReg/iLdReg/iMtReg  in  5 each  destination register.
- iFpuData/iLdData/iMtData  in  32 each  write data.
- oFpuReady/oLdReady/oMtReady  out  1 each  producer may hand over; transfer = valid&ready at posedge.
- iIssueValid  in  1  decode presents a Cop1 instruction.
- iIssueSrc1, iIssueSrc2, iIssueDest  in  5 each  operand/destination registers.
- iIssueUsesSrc2, iIssueWrites  in  1 each  qualifiers for Src2 and Dest.
- oStall  out  1  combinational; instruction must not issue this cycle.
- oRegWrite  out  1  registered write enable to the bank.
- oWriteRegister  out  5  registered write index.
- oWriteData  out  32  registered write data.
- oBusy  out  32  scoreboard view for debug/display.

Behaviour:
- Reset (async, any time, including mid-transfer): all buffers invalid, all wait counters 0, scoreboard 0, oRegWrite=0, oWriteRegister=0, oWriteData=0, ready outputs 1 once released. Any in-flight data is discarded.
- Buffers: one entry per producer.
  - Ready = buffer empty OR buffer granted this cycle.
  - An accepted request loads the buffer at the posedge.
  - No combinational path from valid to ready.
- Arbitration:
  - Each cycle, among valid buffers, pick one.
  - Any buffer whose wait counter equals MAX_WAIT wins first; ties go by fixed order FPU > LWC1 > MTC1.
  - Otherwise, fixed order FPU > LWC1 > MTC1.
- Grant:
  - The winner registers onto oRegWrite/oWriteRegister/oWriteData at the posedge, and its buffer empties.
  - Losers increment their counters, saturating at MAX_WAIT.
  - The winner's counter resets to 0.
  - With no valid buffer, oRegWrite=0 and index/data hold their last values.
- Latency: producer handshake at edge N -> oRegWrite high during cycle N+1 if uncontended. The bank write lands at edge N+2, and the data is readable in cycle N+2. Sustained throughput is 1 write/cycle.
- Scoreboard:
  - Set: the bit for iIssueDest is set at the posedge when iIssueValid & !oStall & iIssueWrites.
  - Clear: the bit for oWriteRegister is cleared at the posedge ending a cycle with oRegWrite=1.
  - Set and clear of the same index in the same cycle: set wins, because a new write is pending.
  - Register 0 is an ordinary FPU register, not hardwired.
- oStall = iIssueValid & (busy[Src1] | (iIssueUsesSrc2 & busy[Src2]) | (iIssueWrites & busy[Dest])). It uses only registered busy bits; there is no bypass.
- Multiple buffered writes to the same register: the arbitration order decides the final value. The scoreboard clears on the first commit. Producers guarantee this cannot occur because WAW stalls at issue.
- A producer writing a register never set busy: accepted and written. The scoreboard is unaffected except for the clear.

Decomposition:
- Shared package cop1_pkg:
  - producer index constants PROD_FPU=0, PROD_LD=1, PROD_MT=2;
  - NUM_PROD=3;
  - the write-request struct typedef {valid, reg[4:0], data[31:0]};
  - FPU_REG_W=5.
- One sub-module is natural: fpu_wb_arbiter (3-way priority with aging counters, grant one-hot out). Buffers, output register and scoreboard stay in the top module.

Test Plan:
- Reset mid-flow: fill all three buffers, assert iCLR between edges -> outputs 0 immediately, oBusy=0, all ready=1 after release, no write ever appears for the discarded entries.
- Single write: MTC1 reg 5 data 0x3F800000 accepted at edge N -> oRegWrite=1, oWriteRegister=5, oWriteData=0x3F800000 in cycle N+1 only.
- Contention: FPU (reg 1) and LWC1 (reg 2) valid continuously with fresh registers each cycle, MAX_WAIT=4 -> LWC1 committed no later than its 5th cycle waiting; MTC1 is never starved either.
- Simultaneous requests: all three accepted at the same edge -> writes in order FPU, LWC1, MTC1 on three consecutive cycles, with ready dropping/rising per the buffer rules.
- Hazard: issue Dest=7 (busy[7]=1), then Src1=7 presented -> oStall=1 until the cycle after the FPU write to reg 7 commits, then 0.
- Set/clear collision: oRegWrite to reg 9 in the same cycle a new issue with Dest=9 is accepted -> busy[9] stays 1.
